// File: rtl/ray_pixel_scheduler.sv
// Frame-level sequencer for the ray pipeline.
// Walks the screen in raster order, issuing one pixel per cycle. A tag shift
// register, as deep as the pipeline's fixed latency, remembers which pixel is
// in flight, so each returning hit/distance is paired with its coordinates.
// Output backpressure freezes the pipeline, the tags and the result register
// together through a single shared stall.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for start; nothing issued
//   S_ISSUE | issuing pixels in raster order, one per non-stalled cycle
//   S_DRAIN | all pixels issued; waiting for in-flight results to leave
module ray_pixel_scheduler #(
  parameter int H_RES        = 800,
  parameter int V_RES        = 600,
  parameter int PIPE_LATENCY = 12,
  parameter int DIST_W       = 16
) (
  input  logic              sysclk,
  input  logic              rst,
  input  logic              start,
  output logic              pipe_stall,
  output logic [9:0]        pixel_x,
  output logic [9:0]        pixel_y,
  output logic              pixel_valid,
  input  logic              hit_in,
  input  logic [DIST_W-1:0] dist_in,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [9:0]        res_x,
  output logic [9:0]        res_y,
  output logic              res_hit,
  output logic [DIST_W-1:0] res_dist,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [9:0] X_LAST = 10'(H_RES - 1);
  localparam logic [9:0] Y_LAST = 10'(V_RES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;

  logic [PIPE_LATENCY-1:0]       tag_v_q, tag_v_d;
  logic [PIPE_LATENCY-1:0][9:0]  tag_x_q, tag_x_d;
  logic [PIPE_LATENCY-1:0][9:0]  tag_y_q, tag_y_d;

  logic              res_valid_q, res_valid_d;
  logic [9:0]        res_x_q, res_x_d;
  logic [9:0]        res_y_q, res_y_d;
  logic              res_hit_q, res_hit_d;
  logic [DIST_W-1:0] res_dist_q, res_dist_d;

  logic stall;
  logic tags_empty;

  // A held result that nobody takes freezes everything upstream.
  assign stall      = res_valid_q & ~res_ready;
  assign tags_empty = (tag_v_q == '0);

  assign pipe_stall = stall;
  assign pixel_x    = x_q;
  assign pixel_y    = y_q;
  assign busy       = (state_q != S_IDLE);
  assign res_valid  = res_valid_q;
  assign res_x      = res_x_q;
  assign res_y      = res_y_q;
  assign res_hit    = res_hit_q;
  assign res_dist   = res_dist_q;

  // Next-state: FSM sequencing, raster counters, tag shift and result load.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    tag_v_d     = tag_v_q;
    tag_x_d     = tag_x_q;
    tag_y_d     = tag_y_q;
    res_valid_d = res_valid_q;
    res_x_d     = res_x_q;
    res_y_d     = res_y_q;
    res_hit_d   = res_hit_q;
    res_dist_d  = res_dist_q;
    pixel_valid = 1'b0;
    frame_done  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (!stall) begin
          pixel_valid = 1'b1;
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              y_d     = '0;
              state_d = S_DRAIN;
            end else begin
              y_d = y_q + 10'd1;
            end
          end else begin
            x_d = x_q + 10'd1;
          end
        end
      end
      S_DRAIN: begin
        // Tags empty means the register holds (or held) the last pixel.
        if (tags_empty && (!res_valid_q || res_ready)) begin
          frame_done = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!stall) begin
      tag_v_d[0] = pixel_valid;
      tag_x_d[0] = x_q;
      tag_y_d[0] = y_q;
      for (int i = 1; i < PIPE_LATENCY; i++) begin
        tag_v_d[i] = tag_v_q[i-1];
        tag_x_d[i] = tag_x_q[i-1];
        tag_y_d[i] = tag_y_q[i-1];
      end
      res_valid_d = tag_v_q[PIPE_LATENCY-1];
      res_x_d     = tag_x_q[PIPE_LATENCY-1];
      res_y_d     = tag_y_q[PIPE_LATENCY-1];
      res_hit_d   = hit_in;
      res_dist_d  = dist_in;
    end
  end

  // State, counter, tag and result registers; reset drops all in-flight work.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      tag_v_q     <= '0;
      tag_x_q     <= '0;
      tag_y_q     <= '0;
      res_valid_q <= 1'b0;
      res_x_q     <= '0;
      res_y_q     <= '0;
      res_hit_q   <= 1'b0;
      res_dist_q  <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      tag_v_q     <= tag_v_d;
      tag_x_q     <= tag_x_d;
      tag_y_q     <= tag_y_d;
      res_valid_q <= res_valid_d;
      res_x_q     <= res_x_d;
      res_y_q     <= res_y_d;
      res_hit_q   <= res_hit_d;
      res_dist_q  <= res_dist_d;
    end
  end

endmodule
